// File: rtl/slot_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : slot_bus_pkg
// Description : Shared widths and master FSM state encoding for the slot bus.
// Revision    : 1.0 - initial release
// ============================================================================
package slot_bus_pkg;

  localparam int SLOT_REG_AW = 5;
  localparam int SLOT_DW     = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } slot_mst_state_t;

endpackage
`default_nettype wire

// File: rtl/slot_decoder.sv
`default_nettype none
// ============================================================================
// Module      : slot_decoder
// Description : Slot index to one-hot chip-select vector plus out-of-range
//               flag. Out-of-range indices produce an all-zero vector.
// Revision    : 1.0 - initial release
// ============================================================================
module slot_decoder #(
  parameter int N_SLOTS = 16,
  parameter int SLOT_W  = 4
) (
  input  logic [SLOT_W-1:0]  i_slot,
  output logic [N_SLOTS-1:0] o_onehot,
  output logic               o_oor
);

  // One-hot decode of populated slots; anything past the last slot flags oor
  always_comb begin
    o_onehot = '0;
    o_oor    = (32'(i_slot) >= 32'(N_SLOTS));
    for (int i = 0; i < N_SLOTS; i++) begin
      if (i_slot == SLOT_W'(i)) begin
        o_onehot[i] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/slot_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : slot_bus_master
// Description : Host-facing initiator for the slot bus. Each accepted request
//               becomes one single-cycle slot access followed by one response.
// Revision    : 1.0 - initial release
// ============================================================================
module slot_bus_master
  import slot_bus_pkg::*;
#(
  parameter int N_SLOTS = 16,
  parameter int SLOT_W  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_req_valid,
  output logic                          o_req_ready,
  input  logic                          i_req_wr,
  input  logic [SLOT_W+SLOT_REG_AW-1:0] i_req_addr,
  input  logic [SLOT_DW-1:0]            i_req_wdata,
  output logic                          o_rsp_valid,
  input  logic                          i_rsp_ready,
  output logic [SLOT_DW-1:0]            o_rsp_rdata,
  output logic                          o_rsp_err,
  output logic [N_SLOTS-1:0]            o_slot_cs,
  output logic                          o_slot_read,
  output logic                          o_slot_write,
  output logic [SLOT_REG_AW-1:0]        o_slot_addr,
  output logic [SLOT_DW-1:0]            o_slot_wr_data,
  input  logic [N_SLOTS*SLOT_DW-1:0]    i_slot_rd_data
);

  slot_mst_state_t          r_state;
  logic                     r_req_ready;
  logic                     r_rsp_valid;
  logic [SLOT_DW-1:0]       r_rsp_rdata;
  logic                     r_rsp_err;
  logic [N_SLOTS-1:0]       r_slot_cs;
  logic                     r_slot_read;
  logic                     r_slot_write;
  logic [SLOT_REG_AW-1:0]   r_slot_addr;
  logic [SLOT_DW-1:0]       r_slot_wr_data;
  logic                     r_wr;
  logic [SLOT_W-1:0]        r_slot;
  logic                     r_err;

  logic [SLOT_W-1:0]        w_req_slot;
  logic [N_SLOTS-1:0]       w_req_cs;
  logic                     w_req_oor;
  logic [SLOT_DW-1:0]       w_rd_sel;

  // Decode straight from the incoming request so the strobes can be
  // registered on the accepting edge and be valid for the whole ISSUE cycle.
  assign w_req_slot = i_req_addr[SLOT_REG_AW +: SLOT_W];

  slot_decoder #(
    .N_SLOTS (N_SLOTS),
    .SLOT_W  (SLOT_W)
  ) u_dec (
    .i_slot   (w_req_slot),
    .o_onehot (w_req_cs),
    .o_oor    (w_req_oor)
  );

  // Select the addressed core's read data; out-of-range slots yield zero
  always_comb begin
    w_rd_sel = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (r_slot == SLOT_W'(i)) begin
        w_rd_sel = i_slot_rd_data[i*SLOT_DW +: SLOT_DW];
      end
    end
  end

  // Master FSM: accept, issue one strobe cycle, hold response until taken
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= IDLE;
      r_req_ready    <= 1'b1;
      r_rsp_valid    <= 1'b0;
      r_rsp_rdata    <= '0;
      r_rsp_err      <= 1'b0;
      r_slot_cs      <= '0;
      r_slot_read    <= 1'b0;
      r_slot_write   <= 1'b0;
      r_slot_addr    <= '0;
      r_slot_wr_data <= '0;
      r_wr           <= 1'b0;
      r_slot         <= '0;
      r_err          <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req_valid && r_req_ready) begin
            r_req_ready    <= 1'b0;
            r_wr           <= i_req_wr;
            r_slot         <= w_req_slot;
            r_err          <= w_req_oor;
            r_slot_cs      <= w_req_cs;
            r_slot_read    <= !i_req_wr && !w_req_oor;
            r_slot_write   <= i_req_wr && !w_req_oor;
            r_slot_addr    <= i_req_addr[SLOT_REG_AW-1:0];
            r_slot_wr_data <= i_req_wdata;
            r_state        <= ISSUE;
          end
        end
        ISSUE: begin
          r_slot_cs    <= '0;
          r_slot_read  <= 1'b0;
          r_slot_write <= 1'b0;
          r_rsp_rdata  <= (r_wr || r_err) ? '0 : w_rd_sel;
          r_rsp_err    <= r_err;
          r_rsp_valid  <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_slot_cs    <= '0;
          r_slot_read  <= 1'b0;
          r_slot_write <= 1'b0;
          r_rsp_valid  <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign o_req_ready    = r_req_ready;
  assign o_rsp_valid    = r_rsp_valid;
  assign o_rsp_rdata    = r_rsp_rdata;
  assign o_rsp_err      = r_rsp_err;
  assign o_slot_cs      = r_slot_cs;
  assign o_slot_read    = r_slot_read;
  assign o_slot_write   = r_slot_write;
  assign o_slot_addr    = r_slot_addr;
  assign o_slot_wr_data = r_slot_wr_data;

endmodule
`default_nettype wire
